// File: rtl/aux_out_ctrl.sv
// aux_out_ctrl: register-programmed driver for the auxiliary output pins.
// Holds DATA/OE registers with atomic set/clear/toggle access and a timed
// one-shot pulse that inverts a pin mask for PULSE_LEN cycles. Pin outputs
// and read data are fully registered so the pad ring never sees decode glitches.
module aux_out_ctrl #(
    parameter int               WIDTH    = 32,
    parameter int               PW       = 16,
    parameter logic [WIDTH-1:0] DATA_RST = '0,
    parameter logic [WIDTH-1:0] OE_RST   = '0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [2:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [WIDTH-1:0] aux_out,
    output logic [WIDTH-1:0] aux_oe,
    output logic             pulse_busy
);

    localparam logic [2:0] A_DATA  = 3'd0;
    localparam logic [2:0] A_SET   = 3'd1;
    localparam logic [2:0] A_CLR   = 3'd2;
    localparam logic [2:0] A_TGL   = 3'd3;
    localparam logic [2:0] A_OE    = 3'd4;
    localparam logic [2:0] A_PLEN  = 3'd5;
    localparam logic [2:0] A_PULSE = 3'd6;

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_oe;
    logic [PW-1:0]    r_plen;
    logic [WIDTH-1:0] r_pmask;
    logic [PW-1:0]    r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] r_aux_out;
    logic [WIDTH-1:0] r_aux_oe;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    logic             w_pulse_start;
    logic [WIDTH-1:0] w_pmask_eff;
    logic [WIDTH-1:0] w_rd_mux;

    // A pulse only starts from IDLE with a non-zero length and a non-empty mask;
    // the length used is the one stored before this cycle's writes.
    assign w_pulse_start = wr_en && (wr_addr == A_PULSE) && (r_state == S_IDLE)
                           && (r_plen != '0) && (wr_data != '0);

    assign w_pmask_eff = (r_state == S_ACTIVE) ? r_pmask : '0;

    // Read mux sees register values from before any same-cycle write.
    always_comb begin
        w_rd_mux = '0;
        case (rd_addr)
            A_DATA:  w_rd_mux = r_data;
            A_OE:    w_rd_mux = r_oe;
            A_PLEN:  w_rd_mux = WIDTH'(r_plen);
            A_PULSE: w_rd_mux = w_pmask_eff;
            default: w_rd_mux = '0;
        endcase
    end

    // DATA register with plain write and atomic set/clear/toggle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_data <= DATA_RST;
        end else if (wr_en) begin
            case (wr_addr)
                A_DATA:  r_data <= wr_data;
                A_SET:   r_data <= r_data | wr_data;
                A_CLR:   r_data <= r_data & ~wr_data;
                A_TGL:   r_data <= r_data ^ wr_data;
                default: r_data <= r_data;
            endcase
        end
    end

    // Output-enable and pulse-length configuration registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_oe   <= OE_RST;
            r_plen <= '0;
        end else if (wr_en) begin
            if (wr_addr == A_OE)
                r_oe <= wr_data;
            if (wr_addr == A_PLEN)
                r_plen <= wr_data[PW-1:0];
        end
    end

    // Pulse FSM: counts PULSE_LEN-1 down to 0 while the mask is applied,
    // then drops back to IDLE; the counter never wraps.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_pmask <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pulse_start) begin
                        r_state <= S_ACTIVE;
                        r_pmask <= wr_data;
                        r_cnt   <= r_plen - PW'(1);
                        r_busy  <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_pmask <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - PW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pmask <= '0;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pin registers: DATA with the active pulse mask inverted; OE passes straight through.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_aux_out <= DATA_RST;
            r_aux_oe  <= OE_RST;
        end else begin
            r_aux_out <= r_data ^ w_pmask_eff;
            r_aux_oe  <= r_oe;
        end
    end

    // Read port: one-cycle latency, data held while no read is pending.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en)
                r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign aux_out    = r_aux_out;
    assign aux_oe     = r_aux_oe;
    assign pulse_busy = r_busy;

endmodule

// File: tb/tb_aux_out_ctrl.sv
// Testbench for aux_out_ctrl: directed register/pulse sequences with a
// scoreboard. Stimulus pushes expected read data and time-stamped pin values;
// a negedge monitor pops and compares them against the DUT.
module tb_aux_out_ctrl;

    logic        sys_clk;
    logic        sys_rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [31:0] aux_out;
    logic [31:0] aux_oe;
    logic        pulse_busy;

    aux_out_ctrl #(
        .WIDTH   (32),
        .PW      (16),
        .DATA_RST(32'h0),
        .OE_RST  (32'h0)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .aux_out   (aux_out),
        .aux_oe    (aux_oe),
        .pulse_busy(pulse_busy)
    );

    typedef struct {
        int          at;
        int          kind;   // 0 aux_out, 1 aux_oe, 2 pulse_busy
        logic [31:0] val;
    } pin_t;

    pin_t        pin_q[$];
    logic [31:0] rd_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares read responses and any pin expectations due this cycle.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_valid_unexpected @cyc %0d: got rd_data 0x%0h expected no response", cyc, rd_data);
                end else begin
                    chk("rd_data", rd_data, rd_q.pop_front());
                end
            end
            for (int i = pin_q.size() - 1; i >= 0; i--) begin
                if (pin_q[i].at <= cyc) begin
                    case (pin_q[i].kind)
                        0:       chk("aux_out", aux_out, pin_q[i].val);
                        1:       chk("aux_oe", aux_oe, pin_q[i].val);
                        default: chk("pulse_busy", {31'b0, pulse_busy}, pin_q[i].val);
                    endcase
                    pin_q.delete(i);
                end
            end
        end
    end

    task automatic exp_pin(input int off, input int kind, input logic [31:0] v);
        pin_t e;
        e.at   = cyc + off;
        e.kind = kind;
        e.val  = v;
        pin_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp);
        rd_en = 1'b1; rd_addr = a;
        rd_q.push_back(exp);
        step(1);
        rd_en = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sys_rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
        #1;
        chk("init_aux_out", aux_out, 32'h0);
        chk("init_busy", {31'b0, pulse_busy}, 32'h0);
        step(2);
        sys_rst = 1'b0;
        step(1);

        // Async reset mid-run with a read response showing.
        wr(3'd0, 32'hA5); exp_pin(1, 0, 32'hA5);
        wr(3'd4, 32'hFF); exp_pin(1, 1, 32'hFF);
        rd_en = 1'b1; rd_addr = 3'd0; rd_q.push_back(32'hA5);
        step(1);
        rd_en = 1'b0;
        #5;
        sys_rst = 1'b1;
        #1;
        chk("rst_aux_out", aux_out, 32'h0);
        chk("rst_aux_oe", aux_oe, 32'h0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_busy", {31'b0, pulse_busy}, 32'h0);
        step(1);
        sys_rst = 1'b0;
        step(1);

        // Atomic DATA ops, OE, write-only and reserved reads.
        wr(3'd0, 32'hF0);  exp_pin(1, 0, 32'hF0);
        wr(3'd1, 32'h0F);  exp_pin(1, 0, 32'hFF);
        wr(3'd2, 32'h30);  exp_pin(1, 0, 32'hCF);
        wr(3'd3, 32'h101); exp_pin(1, 0, 32'h1CE);
        rd(3'd0, 32'h1CE);
        wr(3'd7, 32'hFFFF_FFFF); exp_pin(1, 0, 32'h1CE);
        rd(3'd7, 32'h0);
        rd(3'd1, 32'h0);
        wr(3'd4, 32'h0F); exp_pin(1, 1, 32'h0F);
        rd(3'd4, 32'h0F);
        step(2);

        // Basic pulse: mask 0x3 over DATA 0x1 for 3 cycles.
        wr(3'd0, 32'h1);
        wr(3'd5, 32'h3);
        rd(3'd5, 32'h3);
        wr(3'd6, 32'h3);
        exp_pin(0, 2, 32'h1); exp_pin(1, 2, 32'h1); exp_pin(2, 2, 32'h1); exp_pin(3, 2, 32'h0);
        exp_pin(1, 0, 32'h2); exp_pin(2, 0, 32'h2); exp_pin(3, 0, 32'h2); exp_pin(4, 0, 32'h1);
        rd(3'd6, 32'h3);
        step(4);
        rd(3'd6, 32'h0);
        step(1);

        // Zero length or empty mask: ignored.
        wr(3'd5, 32'h0);
        wr(3'd6, 32'hF);
        exp_pin(0, 2, 32'h0); exp_pin(1, 2, 32'h0); exp_pin(1, 0, 32'h1); exp_pin(2, 0, 32'h1);
        rd(3'd6, 32'h0);
        wr(3'd5, 32'h2);
        wr(3'd6, 32'h0);
        exp_pin(0, 2, 32'h0); exp_pin(1, 0, 32'h1);
        step(2);

        // Re-trigger during ACTIVE ignored; PULSE_LEN change only for next pulse.
        wr(3'd6, 32'h2);
        exp_pin(0, 2, 32'h1); exp_pin(1, 2, 32'h1); exp_pin(2, 2, 32'h0);
        exp_pin(1, 0, 32'h3); exp_pin(2, 0, 32'h3); exp_pin(3, 0, 32'h1);
        wr(3'd6, 32'h4);
        wr(3'd5, 32'h5);
        step(2);
        rd(3'd5, 32'h5);
        rd(3'd6, 32'h0);

        // Maximum length: busy for 65535 cycles, no wrap.
        wr(3'd5, 32'hFFFF);
        wr(3'd6, 32'h1);
        exp_pin(0, 2, 32'h1); exp_pin(65534, 2, 32'h1); exp_pin(65535, 2, 32'h0);
        exp_pin(1, 0, 32'h0); exp_pin(65535, 0, 32'h0); exp_pin(65536, 0, 32'h1);
        step(65538);

        // SET during an active pulse on the same bit; same-cycle OE read/write.
        wr(3'd5, 32'h6);
        wr(3'd6, 32'h4);
        wr(3'd1, 32'h4);
        exp_pin(0, 0, 32'h5); exp_pin(1, 0, 32'h1); exp_pin(5, 0, 32'h1); exp_pin(6, 0, 32'h5);
        exp_pin(4, 2, 32'h1); exp_pin(5, 2, 32'h0);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'h3C;
        rd_en = 1'b1; rd_addr = 3'd4; rd_q.push_back(32'h0F);
        step(1);
        wr_en = 1'b0; rd_en = 1'b0;
        exp_pin(1, 1, 32'h3C);
        rd(3'd4, 32'h3C);
        step(8);

        // Reset mid-pulse: aborted, no resume.
        wr(3'd5, 32'd10);
        wr(3'd6, 32'h8);
        exp_pin(0, 2, 32'h1); exp_pin(1, 0, 32'hD); exp_pin(2, 0, 32'hD);
        step(3);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("midpulse_rst_aux_out", aux_out, 32'h0);
        chk("midpulse_rst_busy", {31'b0, pulse_busy}, 32'h0);
        step(1);
        sys_rst = 1'b0;
        exp_pin(1, 2, 32'h0); exp_pin(5, 2, 32'h0); exp_pin(11, 2, 32'h0);
        exp_pin(1, 0, 32'h0); exp_pin(11, 0, 32'h0);
        step(12);
        rd(3'd6, 32'h0);
        rd(3'd5, 32'h0);
        step(3);

        // Anything still queued never appeared at the DUT outputs.
        if (rd_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL rd_q_leftover: got %0d pending expected 0", rd_q.size());
        end
        if (pin_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL pin_q_leftover: got %0d pending expected 0", pin_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
